fft_twiddle_seq: RTL and testbench
==================================

FFT_TWIDDLE_SEQ -- requirements
Module: fft_twiddle_seq

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the FFT points (radix-2 DIF).
REQ-002 The block SHALL have parameter LOG2N, default 4, giving the stage count, which is `STAGE.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one full FFT sweep.
REQ-006 The block SHALL have port busy, output, 1 bit: high in RUN and DONE states.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the butterfly descriptor is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the butterfly datapath accepts the descriptor.
REQ-009 The block SHALL have port stage, output, 2 bits: current stage, 0 to LOG2N-1.
REQ-010 The block SHALL have ports addr_a and addr_b, output, 4 bits each: butterfly operand addresses.
REQ-011 The block SHALL have port tw_index, output, `STAGE+1 bits: index into the twiddle LUT.
REQ-012 The block SHALL have port last, output, 1 bit: the final descriptor of the sweep.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the sweep completes.
REQ-014 The block SHALL have port inverse, input, 1 bit, present only with TWIDDLE_INVERSE_EN: selects IFFT twiddles.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 In IDLE, start=1 SHALL clear the stage counter s and butterfly counter b, then move to RUN; out_valid SHALL rise on the next cycle.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 out_valid SHALL equal 1 exactly in RUN; a transfer is out_valid&out_ready at a clk edge.
REQ-019 While stalled (out_valid=1, out_ready=0), all descriptor outputs SHALL hold stable.
REQ-020 On each transfer b SHALL increment; at b=N/2-1 it SHALL wrap to 0 and s SHALL increment.
REQ-021 A transfer with s=LOG2N-1 and b=N/2-1 SHALL move the FSM to DONE; last SHALL be 1 only for this descriptor.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; each sweep SHALL emit exactly LOG2N*N/2 = 32 descriptors.
REQ-023 Descriptor fields SHALL be combinational from registered s and b: half = N>>(s+1); j = b mod half; g = b / half; addr_a = 2*g*half + j; addr_b = addr_a + half.
REQ-024 Forward mode SHALL give tw_index = j<<s, range 0..N/2-1, MSB always 0.
REQ-025 All counter arithmetic SHALL be unsigned, with no overflow beyond the stated widths.

Reset
REQ-026 Asserting rst_n=0 SHALL asynchronously force IDLE and s=b=0, making out_valid, busy, done and last 0, with stage, addr_a, addr_b and tw_index at 0.
REQ-027 Reset mid-sweep SHALL abandon the sweep; no done pulse SHALL be issued.
REQ-028 Reset deassertion SHALL be synchronous to clk through the standard 2-flop synchronizer.

Configuration
REQ-029 With TWIDDLE_INVERSE_EN defined and inverse=1, tw_index SHALL be (N - (j<<s)) mod N, the conjugate twiddle for IFFT: 0->0, 1->15, 7->9.
REQ-030 inverse SHALL be sampled when start is accepted and held for the whole sweep.
REQ-031 Without TWIDDLE_INVERSE_EN, the inverse port and its logic SHALL be absent and forward mode is the only mode.

Structure
REQ-032 N, LOG2N, `STAGE and `BITS SHALL live in shared params.v, together with the FSM state encodings.
REQ-033 The block SHALL contain no twiddle values; the top level SHALL connect tw_index to LUT_twiddle.index.
REQ-034 A single sub-module, fft_bfly_addr, SHALL compute addr_a, addr_b and tw_index combinationally from s and b.

Verification
REQ-035 Scenario: reset, start pulse, out_ready=1 -> 32 consecutive descriptors. Stage 0 yields (a,b,tw) = (0,8,0), (1,9,1) ... (7,15,7). Stage 3 yields (0,1,0), (2,3,0) ... (14,15,0). last is on the 32nd, done on the next cycle.
REQ-036 Scenario: stage 1 check -> descriptors b=0..7 give (0,4,0), (1,5,2), (2,6,4), (3,7,6), (8,12,0), (9,13,2), (10,14,4), (11,15,6).
REQ-037 Scenario: random out_ready stalls of 0-5 cycles -> outputs stable during each stall and the sequence identical to REQ-035.
REQ-038 Scenario: start re-pulsed during RUN -> no restart and exactly 32 descriptors.
REQ-039 Scenario: rst_n=0 at descriptor 13 -> outputs zero asynchronously, no done, and a fresh start begins again at (0,8,0).
REQ-040 Scenario: with TWIDDLE_INVERSE_EN and inverse=1 -> stage 0 tw sequence is 0,15,14,13,12,11,10,9.

Source files
------------

// File: rtl/fft_twiddle_seq_pkg.sv
// Shared sizing and FSM encodings for the radix-2 DIF twiddle/address sequencer.
package fft_twiddle_seq_pkg;

  localparam int unsigned FFT_N     = 16;
  localparam int unsigned FFT_LOG2N = 4;
  localparam int unsigned STAGE     = FFT_LOG2N;  // number of FFT stages
  localparam int unsigned BITS      = FFT_LOG2N;  // operand address width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fft_bfly_addr.sv
// Combinational butterfly operand addresses and twiddle index from stage s and butterfly b.
// Optional conjugate twiddles for IFFT when TWIDDLE_INVERSE_EN is defined.
module fft_bfly_addr #(
  parameter int unsigned N     = 16,
  parameter int unsigned LOG2N = 4
) (
  input  logic [$clog2(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]         b,
`ifdef TWIDDLE_INVERSE_EN
  input  logic                     inv,
`endif
  output logic [LOG2N-1:0]         addr_a,
  output logic [LOG2N-1:0]         addr_b,
  output logic [LOG2N:0]           tw_index
);

  localparam int unsigned A_W = LOG2N;
  localparam int unsigned T_W = LOG2N + 1;

  int unsigned half;
  int unsigned j;
  int unsigned g;
  int unsigned a;
  int unsigned tw;

  // half is a power of two, so mod/div reduce to mask/shift
  always_comb begin
    half = N >> (32'(s) + 32'd1);
    j    = 32'(b) & (half - 32'd1);
    g    = 32'(b) >> (LOG2N - 32'd1 - 32'(s));
    a    = (g << (LOG2N - 32'(s))) + j;
    tw   = j << 32'(s);
`ifdef TWIDDLE_INVERSE_EN
    if (inv) tw = (N - tw) & (N - 32'd1);
`endif
    addr_a   = A_W'(a);
    addr_b   = A_W'(a + half);
    tw_index = T_W'(tw);
  end

endmodule

// File: rtl/fft_twiddle_seq.sv
// Radix-2 DIF FFT sweep sequencer: emits LOG2N*N/2 butterfly descriptors with valid/ready.
// Define TWIDDLE_INVERSE_EN to add the inverse input selecting conjugate (IFFT) twiddles.
module fft_twiddle_seq
  import fft_twiddle_seq_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned LOG2N = FFT_LOG2N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
`ifdef TWIDDLE_INVERSE_EN
  input  logic                     inverse,
`endif
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic [LOG2N-1:0]         addr_a,
  output logic [LOG2N-1:0]         addr_b,
  output logic [LOG2N:0]           tw_index,
  output logic                     last,
  output logic                     done
);

  localparam int unsigned S_W = $clog2(LOG2N);
  localparam int unsigned B_W = LOG2N - 1;
  localparam int unsigned A_W = LOG2N;
  localparam int unsigned T_W = LOG2N + 1;
  localparam logic [S_W-1:0] S_LAST = S_W'(LOG2N - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(N / 2 - 1);

  logic [1:0]     rst_sync;
  logic           rst_int_n;
  state_t         state;
  logic [S_W-1:0] s;
  logic [B_W-1:0] b;
  logic           run;
  logic [A_W-1:0] addr_a_c;
  logic [A_W-1:0] addr_b_c;
  logic [T_W-1:0] tw_index_c;
`ifdef TWIDDLE_INVERSE_EN
  logic           inv;
`endif

  // Reset asserts asynchronously, releases two clock edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= ST_IDLE;
      s     <= '0;
      b     <= '0;
`ifdef TWIDDLE_INVERSE_EN
      inv   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            s     <= '0;
            b     <= '0;
`ifdef TWIDDLE_INVERSE_EN
            inv   <= inverse;
`endif
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            if (b == B_LAST) begin
              b <= '0;
              if (s == S_LAST) begin
                s     <= '0;
                state <= ST_DONE;
              end else begin
                s <= s + S_W'(1);
              end
            end else begin
              b <= b + B_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  fft_bfly_addr #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_bfly_addr (
    .s        (s),
    .b        (b),
`ifdef TWIDDLE_INVERSE_EN
    .inv      (inv),
`endif
    .addr_a   (addr_a_c),
    .addr_b   (addr_b_c),
    .tw_index (tw_index_c)
  );

  // Descriptor fields read as zero whenever no descriptor is offered
  assign run       = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign out_valid = run;
  assign done      = (state == ST_DONE);
  assign last      = run && (s == S_LAST) && (b == B_LAST);
  assign stage     = run ? s          : '0;
  assign addr_a    = run ? addr_a_c   : '0;
  assign addr_b    = run ? addr_b_c   : '0;
  assign tw_index  = run ? tw_index_c : '0;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Directed self-checking bench for fft_twiddle_seq: full sweep, stalls, restart, mid-sweep reset.
module tb_fft_twiddle_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
`ifdef TWIDDLE_INVERSE_EN
  logic       inverse = 1'b0;
`endif
  logic       busy;
  logic       out_valid;
  logic [1:0] stage;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [4:0] tw_index;
  logic       last;
  logic       done;

  int tests = 0;
  int fails = 0;

  // Hand-derived descriptor sequence for N=16, in transfer order
  int exp_a  [32] = '{0,1,2,3,4,5,6,7,  0,1,2,3,8,9,10,11,  0,1,4,5,8,9,12,13,  0,2,4,6,8,10,12,14};
  int exp_b  [32] = '{8,9,10,11,12,13,14,15,  4,5,6,7,12,13,14,15,  2,3,6,7,10,11,14,15,  1,3,5,7,9,11,13,15};
  int exp_tw [32] = '{0,1,2,3,4,5,6,7,  0,2,4,6,0,2,4,6,  0,4,0,4,0,4,0,4,  0,0,0,0,0,0,0,0};

  always #5 clk = ~clk;

  fft_twiddle_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef TWIDDLE_INVERSE_EN
    .inverse   (inverse),
`endif
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stage     (stage),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_index  (tw_index),
    .last      (last),
    .done      (done)
  );

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, done, last} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got valid/busy/done/last=%b, want 0000", {out_valid, busy, done, last});
    end
    tests++;
    if ({stage, addr_a, addr_b, tw_index} !== 15'd0) begin
      fails++;
      $display("FAIL reset_fields: got stage=%0d a=%0d b=%0d tw=%0d, want all 0", stage, addr_a, addr_b, tw_index);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({out_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got valid/busy/done=%b, want 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_sweep();
    int cnt = 0;
    int cyc = 0;
    out_ready = 1'b1;
    pulse_start();
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL sweep_valid_rise: got valid=%b busy=%b, want 1 1", out_valid, busy);
    end
    while (cnt < 32 && cyc < 200) begin
      if (out_valid) begin
        tests++;
        if ({stage, addr_a, addr_b, tw_index, last} !==
            {2'(cnt / 8), 4'(exp_a[cnt]), 4'(exp_b[cnt]), 5'(exp_tw[cnt]), (cnt == 31)}) begin
          fails++;
          $display("FAIL sweep_desc[%0d]: got s=%0d a=%0d b=%0d tw=%0d last=%b, want s=%0d a=%0d b=%0d tw=%0d last=%b",
                   cnt, stage, addr_a, addr_b, tw_index, last,
                   cnt / 8, exp_a[cnt], exp_b[cnt], exp_tw[cnt], (cnt == 31));
        end
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cnt != 32) begin
      fails++;
      $display("FAIL sweep_count: got %0d descriptors, want 32", cnt);
    end
    tests++;
    if ({done, busy, out_valid, last} !== 4'b1100) begin
      fails++;
      $display("FAIL sweep_done: got done/busy/valid/last=%b, want 1100", {done, busy, out_valid, last});
    end
    @(negedge clk);
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL sweep_done_pulse: got done/busy=%b, want 00", {done, busy});
    end
  endtask

  task automatic test_stall();
    int cnt = 0;
    int cyc = 0;
    int stall_left = 2;
    bit have_prev = 0;
    logic [15:0] prev = '0;
    pulse_start();
    while (cnt < 32 && cyc < 400) begin
      if (have_prev) begin
        tests++;
        if ({out_valid, stage, addr_a, addr_b, tw_index, last} !== {1'b1, prev[15:1], prev[0]}) begin
          fails++;
          $display("FAIL stall_hold[%0d]: got valid=%b s=%0d a=%0d b=%0d tw=%0d, want held s=%0d a=%0d b=%0d tw=%0d",
                   cnt, out_valid, stage, addr_a, addr_b, tw_index,
                   prev[15:14], prev[13:10], prev[9:6], prev[5:1]);
        end
        have_prev = 0;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (out_valid) begin
          prev = {stage, addr_a, addr_b, tw_index, last};
          have_prev = 1;
        end
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          tests++;
          if ({stage, addr_a, addr_b, tw_index} !==
              {2'(cnt / 8), 4'(exp_a[cnt]), 4'(exp_b[cnt]), 5'(exp_tw[cnt])}) begin
            fails++;
            $display("FAIL stall_desc[%0d]: got s=%0d a=%0d b=%0d tw=%0d, want s=%0d a=%0d b=%0d tw=%0d",
                     cnt, stage, addr_a, addr_b, tw_index, cnt / 8, exp_a[cnt], exp_b[cnt], exp_tw[cnt]);
          end
          cnt++;
          stall_left = $urandom_range(0, 5);
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    tests++;
    if (cnt != 32 || done !== 1'b1) begin
      fails++;
      $display("FAIL stall_count: got %0d descriptors done=%b, want 32 1", cnt, done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int cyc = 0;
    out_ready = 1'b1;
    pulse_start();
    while (cnt < 32 && cyc < 200) begin
      start = (cnt == 5 || cnt == 31);
      if (out_valid) cnt++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (cnt != 32 || done !== 1'b1) begin
      fails++;
      $display("FAIL restart_count: got %0d descriptors done=%b, want 32 1", cnt, done);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({out_valid, busy} !== 2'b00) begin
        fails++;
        $display("FAIL restart_ignored: got valid/busy=%b, want 00", {out_valid, busy});
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    int cyc = 0;
    bit seen_done = 0;
    out_ready = 1'b1;
    pulse_start();
    while (cnt < 13 && cyc < 100) begin
      if (out_valid) cnt++;
      @(negedge clk);
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, done, last, stage, addr_a, addr_b, tw_index} !== 19'd0) begin
      fails++;
      $display("FAIL midreset_async: got valid=%b busy=%b done=%b last=%b s=%0d a=%0d b=%0d tw=%0d, want all 0",
               out_valid, busy, done, last, stage, addr_a, addr_b, tw_index);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL midreset_no_done: got done=%b, want 0", done);
      end
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if ({done, busy} !== 2'b00) begin
        fails++;
        $display("FAIL midreset_release: got done/busy=%b, want 00", {done, busy});
      end
    end
    pulse_start();
    tests++;
    if ({out_valid, stage, addr_a, addr_b, tw_index} !== {1'b1, 2'd0, 4'd0, 4'd8, 5'd0}) begin
      fails++;
      $display("FAIL midreset_fresh: got valid=%b s=%0d a=%0d b=%0d tw=%0d, want 1 0 0 8 0",
               out_valid, stage, addr_a, addr_b, tw_index);
    end
    cyc = 0;
    while (!seen_done && cyc < 60) begin
      if (done) seen_done = 1;
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL midreset_sweep_done: got no done within 60 cycles, want done");
    end
  endtask

`ifdef TWIDDLE_INVERSE_EN
  task automatic test_inverse();
    int exp_inv [8] = '{0,15,14,13,12,11,10,9};
    int cnt = 0;
    int cyc = 0;
    out_ready = 1'b1;
    inverse = 1'b1;
    pulse_start();
    inverse = 1'b0;
    while (cnt < 8 && cyc < 50) begin
      if (out_valid) begin
        tests++;
        if ({addr_a, addr_b, tw_index} !== {4'(exp_a[cnt]), 4'(exp_b[cnt]), 5'(exp_inv[cnt])}) begin
          fails++;
          $display("FAIL inverse_desc[%0d]: got a=%0d b=%0d tw=%0d, want a=%0d b=%0d tw=%0d",
                   cnt, addr_a, addr_b, tw_index, exp_a[cnt], exp_b[cnt], exp_inv[cnt]);
        end
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef TWIDDLE_INVERSE_EN
    test_inverse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
